alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential issue controller that drives the 32-bit datapath ALU. It accepts one R-type instruction plus its two register operands over a valid/ready handshake, decodes the funct field into the ALU's 6-bit function code, and presents registered operands to the ALU for one execute cycle. It then captures the ALU's result and flags into an output buffer held under valid/ready backpressure. It sits between the register-read stage and writeback, as the initiator side of the ALU's `d1`/`d2`/`func` → `s`/`cout`/`zero_detect` interface.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-operation counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  instruction/operands valid.
- `in_ready`  out  1  controller can accept.
- `instr`  in  32  instruction word.
- `rs_val`  in  32  value of the register in `instr[25:21]`.
- `rt_val`  in  32  value of the register in `instr[20:16]`.
- `alu_d1`  out  32  ALU operand 1.
- `alu_d2`  out  32  ALU operand 2.
- `alu_func`  out  6  ALU function code.
- `alu_s`  in  32  ALU result.
- `alu_cout`  in  1  ALU carry-out.
- `alu_zero`  in  1  ALU zero detect.
- `out_valid`  out  1  result buffer valid.
- `out_ready`  in  1  downstream accepts result.
- `out_result`  out  32  captured result.
- `out_rd`  out  5  destination register, `instr[15:11]`.
- `out_cout`  out  1  captured carry-out.
- `out_zero`  out  1  captured zero flag.
- `out_illegal`  out  1  instruction not supported.
- `retired_cnt`  out  CNT_W  count of results consumed downstream.

## Operation
- The FSM has three states, and IDLE is the reset state.
  - **IDLE:** `in_ready`=1. On `in_valid`, latch the decoded func, operands, rd and illegal flag, then go to EXEC.
  - **EXEC:** one cycle. The registered operands and func drive the ALU. At the end of the cycle, capture `alu_s`, `alu_cout` and `alu_zero`, then go to HOLD.
  - **HOLD:** `out_valid`=1. When `out_ready`=1, increment `retired_cnt` (wraps modulo 2^CNT_W) and go to IDLE.
- `in_ready` is 1 only in IDLE and is forced to 0 while `rst`=1.
- Decode applies only when `instr[31:26]`=000000; any other opcode is illegal.
- Immediate shifts use `d1`=`rt_val` and `d2`={27'b0, `instr[10:6]`}:
  - funct 000000 → func 000100 (sll).
  - funct 000010 → func 000110 (srl).
  - funct 000011 → func 000111 (sra).
- Variable shifts use `d1`=`rt_val` and `d2`=`rs_val`:
  - funct 000100 → func 000100.
  - funct 000110 → func 000110.
  - funct 000111 → func 000111.
- Funct 100000–100110 and 101000–101101 pass through unchanged as func, with `d1`=`rs_val` and `d2`=`rt_val`.
- Any other funct is illegal. For an illegal instruction:
  - func is driven as 000000 and both operands are 0.
  - EXEC still occurs.
  - The captured result, cout and zero are forced to 0, and `out_illegal`=1.
  - The instruction is still retired through HOLD and counted.
- Outside EXEC, `alu_func`=000000 and `alu_d1`/`alu_d2` hold their last values. Only EXEC-cycle ALU outputs are ever sampled.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid`, `out_result`, `out_rd`, `out_cout`, `out_zero`, `out_illegal` = 0.
  - `alu_d1`, `alu_d2`, `alu_func` = 0.
  - `retired_cnt` = 0.
- Accept at edge N; EXEC during cycle N+1; `out_valid`=1 from edge N+2.
- Throughput is at most one instruction per 3 cycles.
- `out_*` are stable while `out_valid`=1 and `out_ready`=0.
- If `out_ready` is already 1 when HOLD is entered, the handshake completes at the next edge. `in_ready` rises that same edge.
- `in_valid` during EXEC or HOLD is ignored; the upstream holds its data.
- `rst` asserted mid-operation discards the in-flight instruction and any unconsumed result without counting it. Outputs take their reset values asynchronously.

## Structure
- Shared package `alu_pkg` holds:
  - ALU func constants: `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_ADD`, `ALU_ADDU`, `ALU_SUB`, `ALU_SUBU`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_SEQ`, `ALU_SNE`, `ALU_SLT`, `ALU_SGT`, `ALU_SLE`, `ALU_SGE`, `ALU_NOP`=000000.
  - Funct-field constants.
  - The state encoding (IDLE, EXEC, HOLD).
- Sub-module `alu_funct_decode` is combinational. It maps `instr`, `rs_val` and `rt_val` to func, d1, d2 and illegal.
- The top level contains the FSM, registers and counter.

## Test plan
- **add:** `instr`=0x01095020 (add rd=10, rs=8, rt=9), `rs_val`=5, `rt_val`=7, ALU model returns `s`=12. Expect:
  - func 100000 during EXEC only.
  - `out_valid` at accept+2.
  - `out_result`=12, `out_rd`=10, `out_zero`=0, `retired_cnt`=1 after consume.
- **sll immediate:** `instr`=0x00094100 (shamt 4, rd 8), `rt_val`=0x1. Expect:
  - `alu_d1`=1, `alu_d2`=4, `alu_func`=000100.
  - `out_result`=0x10.
- **Backpressure:** `out_ready`=0 for 5 cycles in HOLD. Expect:
  - `out_*` constant and `in_ready`=0 throughout.
  - `in_valid` pulses ignored.
  - Release → IDLE next cycle.
- **Illegal:** `instr`=0x20010005 (opcode 001000). Expect:
  - `out_illegal`=1, `out_result`=0, `alu_func`=000000.
  - Counter increments.
- **Reset mid-EXEC:** assert `rst` during EXEC. Expect:
  - `out_valid`=0, `retired_cnt` unchanged from 0.
  - `in_ready`=1 the first cycle after deassert.
- **Wrap:** with `CNT_W`=4, retire 17 instructions. Expect `retired_cnt`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, R-type funct fields, issue FSM states
package alu_pkg;
   localparam logic [5:0] ALU_NOP  = 6'b000000;
   localparam logic [5:0] ALU_SLL  = 6'b000100;
   localparam logic [5:0] ALU_SRL  = 6'b000110;
   localparam logic [5:0] ALU_SRA  = 6'b000111;
   localparam logic [5:0] ALU_ADD  = 6'b100000;
   localparam logic [5:0] ALU_ADDU = 6'b100001;
   localparam logic [5:0] ALU_SUB  = 6'b100010;
   localparam logic [5:0] ALU_SUBU = 6'b100011;
   localparam logic [5:0] ALU_AND  = 6'b100100;
   localparam logic [5:0] ALU_OR   = 6'b100101;
   localparam logic [5:0] ALU_XOR  = 6'b100110;
   localparam logic [5:0] ALU_SEQ  = 6'b101000;
   localparam logic [5:0] ALU_SNE  = 6'b101001;
   localparam logic [5:0] ALU_SLT  = 6'b101010;
   localparam logic [5:0] ALU_SGT  = 6'b101011;
   localparam logic [5:0] ALU_SLE  = 6'b101100;
   localparam logic [5:0] ALU_SGE  = 6'b101101;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_SLLV  = 6'b000100;
   localparam logic [5:0] FN_SRLV  = 6'b000110;
   localparam logic [5:0] FN_SRAV  = 6'b000111;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EXEC   = 2'd1;
   localparam logic [1:0] S_HOLD   = 2'd2;
   // funct values 100000..100110 and 101000..101101 are handed to the ALU unchanged
   function automatic logic is_pass_funct(input logic [5:0] f);
      return (f[5:3] == 3'b100 && f[2:0] != 3'b111) || (f[5:3] == 3'b101 && f[2:0] <= 3'd5);
   endfunction
endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: combinational R-type decode to ALU func code and operands
//   instr, rs_val, rt_val : instruction word and its two register values
//   func, d1, d2          : ALU function code and operands (all zero when illegal)
//   illegal               : opcode or funct not supported
module alu_funct_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [5:0]  func,
   output logic [31:0] d1,
   output logic [31:0] d2,
   output logic        illegal
);
   logic [5:0] w_funct;
   logic       w_imm;
   logic       w_var;
   logic       w_unused;
   assign w_funct  = instr[5:0];
   assign w_imm    = w_funct == FN_SLL || w_funct == FN_SRL || w_funct == FN_SRA;
   assign w_var    = w_funct == FN_SLLV || w_funct == FN_SRLV || w_funct == FN_SRAV;
   assign w_unused = ^instr[25:11];
   assign illegal  = !(instr[31:26] == OP_RTYPE && (w_imm || w_var || is_pass_funct(w_funct)));
   // immediate shift functs differ from their variable forms only in bit 2
   assign func     = illegal ? ALU_NOP : w_imm ? (w_funct | FN_SLLV) : w_funct;
   // shifts put the shifted value (rt) on d1 and the amount on d2
   assign d1       = illegal ? 32'd0 : (w_imm || w_var) ? rt_val : rs_val;
   assign d2       = illegal ? 32'd0 : w_imm ? {27'd0, instr[10:6]} : w_var ? rs_val : rt_val;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one R-type op to the ALU and buffers its result
//   clk, rst                          : clock, async active-high reset
//   in_valid/in_ready, instr, rs_val, rt_val : instruction intake
//   alu_d1, alu_d2, alu_func          : ALU operands and function (NOP outside EXEC)
//   alu_s, alu_cout, alu_zero         : ALU result, sampled at the end of EXEC
//   out_valid/out_ready, out_*        : buffered result toward writeback
//   retired_cnt                       : results consumed downstream, wraps
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [31:0]      rs_val,
   input  logic [31:0]      rt_val,
   output logic [31:0]      alu_d1,
   output logic [31:0]      alu_d2,
   output logic [5:0]       alu_func,
   input  logic [31:0]      alu_s,
   input  logic             alu_cout,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [4:0]       out_rd,
   output logic             out_cout,
   output logic             out_zero,
   output logic             out_illegal,
   output logic [CNT_W-1:0] retired_cnt
);
   logic [1:0]       r_state;
   logic [5:0]       r_func;
   logic [31:0]      r_d1;
   logic [31:0]      r_d2;
   logic [4:0]       r_rd;
   logic             r_ill;
   logic [31:0]      r_result;
   logic             r_cout;
   logic             r_zero;
   logic [CNT_W-1:0] r_cnt;
   logic [5:0]       w_func;
   logic [31:0]      w_d1;
   logic [31:0]      w_d2;
   logic             w_ill;
   alu_funct_decode u_dec (
      .instr   (instr),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .func    (w_func),
      .d1      (w_d1),
      .d2      (w_d2),
      .illegal (w_ill)
   );
   assign in_ready    = r_state == S_IDLE && !rst;
   assign out_valid   = r_state == S_HOLD;
   assign alu_func    = r_state == S_EXEC ? r_func : ALU_NOP;
   assign alu_d1      = r_d1;
   assign alu_d2      = r_d2;
   assign out_result  = r_result;
   assign out_rd      = r_rd;
   assign out_cout    = r_cout;
   assign out_zero    = r_zero;
   assign out_illegal = r_ill;
   assign retired_cnt = r_cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_func   <= ALU_NOP;
         r_d1     <= '0;
         r_d2     <= '0;
         r_rd     <= '0;
         r_ill    <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_zero   <= 1'b0;
         r_cnt    <= '0;
      end else if (r_state == S_IDLE && in_valid) begin
         r_func  <= w_func;
         r_d1    <= w_d1;
         r_d2    <= w_d2;
         r_rd    <= instr[15:11];
         r_ill   <= w_ill;
         r_state <= S_EXEC;
      end else if (r_state == S_EXEC) begin
         // an illegal op still spends its EXEC cycle but never exposes ALU outputs
         r_result <= r_ill ? 32'd0 : alu_s;
         r_cout   <= !r_ill && alu_cout;
         r_zero   <= !r_ill && alu_zero;
         r_state  <= S_HOLD;
      end else if (r_state == S_HOLD && out_ready) begin
         r_cnt   <= r_cnt + 1'b1;
         r_state <= S_IDLE;
      end else if (r_state != S_IDLE && r_state != S_HOLD) begin
         // unused encoding recovers to IDLE
         r_state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vector bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;
   import alu_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic [31:0] alu_d1;
   logic [31:0] alu_d2;
   logic [5:0]  alu_func;
   logic [31:0] alu_s;
   logic        alu_cout;
   logic        alu_zero;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_cout;
   logic        out_zero;
   logic        out_illegal;
   logic [3:0]  retired_cnt;
   logic [3:0]  exp_cnt = '0;
   logic [32:0] m_sum;
   int          n_cmp = 0;
   int          n_err = 0;
   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [5:0]  func;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] res;
      logic [4:0]  rd;
      logic        cout;
      logic        zero;
      logic        ill;
   } vec_t;
   vec_t vecs [11];
   alu_issue_ctrl #(.CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .alu_d1      (alu_d1),
      .alu_d2      (alu_d2),
      .alu_func    (alu_func),
      .alu_s       (alu_s),
      .alu_cout    (alu_cout),
      .alu_zero    (alu_zero),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_rd      (out_rd),
      .out_cout    (out_cout),
      .out_zero    (out_zero),
      .out_illegal (out_illegal),
      .retired_cnt (retired_cnt)
   );
   always #5 clk = ~clk;
   // behavioural ALU; NOP returns junk with both flags set so forced-zero capture is visible
   always_comb begin
      m_sum    = 33'd0;
      alu_s    = 32'hA5A5_A5A5;
      alu_cout = 1'b0;
      case (alu_func)
         ALU_SLL:           alu_s = alu_d1 << alu_d2[4:0];
         ALU_SRL:           alu_s = alu_d1 >> alu_d2[4:0];
         ALU_SRA:           alu_s = $unsigned($signed(alu_d1) >>> alu_d2[4:0]);
         ALU_ADD, ALU_ADDU: begin
            m_sum    = {1'b0, alu_d1} + {1'b0, alu_d2};
            alu_s    = m_sum[31:0];
            alu_cout = m_sum[32];
         end
         ALU_SUB, ALU_SUBU: begin
            m_sum    = {1'b0, alu_d1} + {1'b0, ~alu_d2} + 33'd1;
            alu_s    = m_sum[31:0];
            alu_cout = m_sum[32];
         end
         ALU_AND:           alu_s = alu_d1 & alu_d2;
         ALU_OR:            alu_s = alu_d1 | alu_d2;
         ALU_XOR:           alu_s = alu_d1 ^ alu_d2;
         ALU_SEQ:           alu_s = {31'd0, alu_d1 == alu_d2};
         ALU_SNE:           alu_s = {31'd0, alu_d1 != alu_d2};
         ALU_SLT:           alu_s = {31'd0, $signed(alu_d1) < $signed(alu_d2)};
         ALU_SGT:           alu_s = {31'd0, $signed(alu_d1) > $signed(alu_d2)};
         ALU_SLE:           alu_s = {31'd0, $signed(alu_d1) <= $signed(alu_d2)};
         ALU_SGE:           alu_s = {31'd0, $signed(alu_d1) >= $signed(alu_d2)};
         default:           alu_cout = 1'b1;
      endcase
      alu_zero = alu_func == ALU_NOP ? 1'b1 : alu_s == 32'd0;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic run_op(input vec_t v, input int hold);
      int t;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      instr    = v.instr;
      rs_val   = v.rs;
      rt_val   = v.rt;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("exec_func", 32'(alu_func), 32'(v.func));
      chk("exec_d1", alu_d1, v.d1);
      chk("exec_d2", alu_d2, v.d2);
      chk("exec_out_valid", 32'(out_valid), 32'd0);
      chk("exec_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, v.res);
      chk("hold_rd", 32'(out_rd), 32'(v.rd));
      chk("hold_cout", 32'(out_cout), 32'(v.cout));
      chk("hold_zero", 32'(out_zero), 32'(v.zero));
      chk("hold_illegal", 32'(out_illegal), 32'(v.ill));
      chk("hold_func_nop", 32'(alu_func), 32'd0);
      chk("hold_d1_kept", alu_d1, v.d1);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         instr    = 32'h0000_0020 + i;
         @(negedge clk);
         in_valid = 1'b0;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_result", out_result, v.res);
         chk("bp_rd", 32'(out_rd), 32'(v.rd));
         chk("bp_flags", {29'd0, out_cout, out_zero, out_illegal}, {29'd0, v.cout, v.zero, v.ill});
         chk("bp_cnt", 32'(retired_cnt), 32'(exp_cnt));
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      exp_cnt   = exp_cnt + 4'd1;
      chk("done_out_valid", 32'(out_valid), 32'd0);
      chk("done_in_ready", 32'(in_ready), 32'd1);
      chk("done_cnt", 32'(retired_cnt), 32'(exp_cnt));
   endtask
   initial begin
      vecs[0]  = '{32'h0109_5020, 32'd5,          32'd7,          ALU_ADD,  32'd5,          32'd7,          32'd12,         5'd10, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'h0009_4100, 32'h0000_DEAD,  32'd1,          ALU_SLL,  32'd1,          32'd4,          32'h10,         5'd8,  1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'h2001_0005, 32'd3,          32'd4,          ALU_NOP,  32'd0,          32'd0,          32'd0,          5'd0,  1'b0, 1'b0, 1'b1};
      vecs[3]  = '{32'h0022_1822, 32'd9,          32'd9,          ALU_SUB,  32'd9,          32'd9,          32'd0,          5'd3,  1'b1, 1'b1, 1'b0};
      vecs[4]  = '{32'h0085_3021, 32'hFFFF_FFFF,  32'd2,          ALU_ADDU, 32'hFFFF_FFFF,  32'd2,          32'd1,          5'd6,  1'b1, 1'b0, 1'b0};
      vecs[5]  = '{32'h0022_3807, 32'd4,          32'h8000_0000,  ALU_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  5'd7,  1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'h0003_FA03, 32'h55,         32'h8000_0000,  ALU_SRA,  32'h8000_0000,  32'd8,          32'hFF80_0000,  5'd31, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{32'h0000_0827, 32'd3,          32'd4,          ALU_NOP,  32'd0,          32'd0,          32'd0,          5'd1,  1'b0, 1'b0, 1'b1};
      vecs[8]  = '{32'h0022_102D, 32'd5,          32'd5,          ALU_SGE,  32'd5,          32'd5,          32'd1,          5'd2,  1'b0, 1'b0, 1'b0};
      vecs[9]  = '{32'h0000_002E, 32'd1,          32'd1,          ALU_NOP,  32'd0,          32'd0,          32'd0,          5'd0,  1'b0, 1'b0, 1'b1};
      vecs[10] = '{32'h0043_2026, 32'hF0F0_F0F0,  32'hFFFF_0000,  ALU_XOR,  32'hF0F0_F0F0,  32'hFFFF_0000,  32'h0F0F_F0F0,  5'd4,  1'b0, 1'b0, 1'b0};
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_bus", out_result | {27'd0, out_rd} | {29'd0, out_cout, out_zero, out_illegal}, 32'd0);
      chk("rst_alu", alu_d1 | alu_d2 | {26'd0, alu_func}, 32'd0);
      chk("rst_cnt", 32'(retired_cnt), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      // reset asserted during EXEC drops the op without counting it
      instr    = vecs[0].instr;
      rs_val   = vecs[0].rs;
      rt_val   = vecs[0].rt;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_exec_func", 32'(alu_func), 32'(ALU_ADD));
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_alu", alu_d1 | {26'd0, alu_func}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_cnt", 32'(retired_cnt), 32'd0);
      for (int i = 0; i < 11; i++) run_op(vecs[i], 0);
      run_op(vecs[3], 5);
      // out_ready already high when HOLD is entered: one-cycle HOLD
      instr    = vecs[1].instr;
      rs_val   = vecs[1].rs;
      rt_val   = vecs[1].rt;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("fast_out_valid", 32'(out_valid), 32'd1);
      chk("fast_result", out_result, 32'h10);
      @(negedge clk);
      out_ready = 1'b0;
      exp_cnt   = exp_cnt + 4'd1;
      chk("fast_done_valid", 32'(out_valid), 32'd0);
      chk("fast_in_ready", 32'(in_ready), 32'd1);
      chk("fast_cnt", 32'(retired_cnt), 32'(exp_cnt));
      // counter wrap: 17 retirements from reset leave a 4-bit counter at 1
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      exp_cnt = '0;
      chk("wrap_start", 32'(retired_cnt), 32'd0);
      for (int i = 0; i < 17; i++) run_op(vecs[i % 11], 0);
      chk("wrap_cnt", 32'(retired_cnt), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
